// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one ALU between N requesters, returning
// results per requester and forcing a quiet-NaN response if the ALU stalls.
module alu_arbiter #(
    parameter int          N              = 2,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RESULT = 32'h7FC00000,
    localparam int         GW             = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [32*N-1:0] req_op_a,
    input  logic [32*N-1:0] req_op_b,
    input  logic [3*N-1:0]  req_op_code,
    input  logic [N-1:0]    req_mode_fp,
    input  logic [2*N-1:0]  req_round_mode,
    output logic [N-1:0]    resp_valid,
    input  logic [N-1:0]    resp_ready,
    output logic [31:0]     resp_result,
    output logic [4:0]      resp_flags,
    output logic            resp_timeout,
    output logic [31:0]     alu_op_a,
    output logic [31:0]     alu_op_b,
    output logic [2:0]      alu_op_code,
    output logic            alu_mode_fp,
    output logic [1:0]      alu_round_mode,
    output logic            alu_start,
    input  logic [31:0]     alu_result,
    input  logic            alu_valid_out,
    input  logic [4:0]      alu_flags,
    output logic            busy,
    output logic [GW-1:0]   grant_id
);

    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESPOND
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [GW-1:0] rr_ptr;
    logic [WW-1:0] watchdog;
    logic [GW-1:0] pick_idx;
    logic          pick_found;
    logic [31:0]   sel_op_a;
    logic [31:0]   sel_op_b;
    logic [2:0]    sel_op_code;
    logic          sel_mode_fp;
    logic [1:0]    sel_round_mode;
    logic          grant_en;
    logic          done_ok;
    logic          done_timeout;
    logic          wd_clear;

    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return GW'(sum);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [GW-1:0] idx);
        logic [N-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // First pending requester at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!pick_found && req_valid[wrap_add(rr_ptr, i)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(rr_ptr, i);
            end
        end
    end

    always_comb begin
        sel_op_a       = '0;
        sel_op_b       = '0;
        sel_op_code    = '0;
        sel_mode_fp    = 1'b0;
        sel_round_mode = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == GW'(i)) begin
                sel_op_a       = req_op_a[32*i +: 32];
                sel_op_b       = req_op_b[32*i +: 32];
                sel_op_code    = req_op_code[3*i +: 3];
                sel_mode_fp    = req_mode_fp[i];
                sel_round_mode = req_round_mode[2*i +: 2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // alu_start is decoded from state so an asynchronous reset drops it at once.
    always_comb begin
        next_state   = state;
        req_ready    = '0;
        resp_valid   = '0;
        alu_start    = 1'b0;
        busy         = (state != IDLE);
        grant_en     = 1'b0;
        done_ok      = 1'b0;
        done_timeout = 1'b0;
        wd_clear     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    req_ready  = onehot(pick_idx);
                    grant_en   = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                alu_start = 1'b1;
                if (alu_valid_out) begin
                    done_ok    = 1'b1;
                    next_state = DRAIN;
                end else if (watchdog == WW'(TIMEOUT_CYCLES - 1)) begin
                    done_timeout = 1'b1;
                    next_state   = DRAIN;
                end
            end
            DRAIN: begin
                if (!alu_valid_out) begin
                    next_state = RESPOND;
                end
            end
            RESPOND: begin
                resp_valid = onehot(grant_id);
                if (resp_ready[grant_id]) begin
                    wd_clear   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_op_a       <= '0;
            alu_op_b       <= '0;
            alu_op_code    <= '0;
            alu_mode_fp    <= 1'b0;
            alu_round_mode <= '0;
            grant_id       <= '0;
            rr_ptr         <= '0;
            watchdog       <= '0;
            resp_result    <= '0;
            resp_flags     <= '0;
            resp_timeout   <= 1'b0;
        end else begin
            if (grant_en) begin
                alu_op_a       <= sel_op_a;
                alu_op_b       <= sel_op_b;
                alu_op_code    <= sel_op_code;
                alu_mode_fp    <= sel_mode_fp;
                alu_round_mode <= sel_round_mode;
                grant_id       <= pick_idx;
                rr_ptr         <= wrap_add(pick_idx, 1);
            end
            if (wd_clear) begin
                watchdog <= '0;
            end else if (state == ISSUE) begin
                watchdog <= watchdog + 1'b1;
            end
            if (done_ok) begin
                resp_result  <= alu_result;
                resp_flags   <= alu_flags;
                resp_timeout <= 1'b0;
            end else if (done_timeout) begin
                resp_result  <= TIMEOUT_RESULT;
                resp_flags   <= 5'b10000;
                resp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters and a behavioural ALU stub
// whose latency, stall and valid-hold behaviour are controlled per scenario.
module tb_alu_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_op_a;
    logic [32*N-1:0] req_op_b;
    logic [3*N-1:0]  req_op_code;
    logic [N-1:0]    req_mode_fp;
    logic [2*N-1:0]  req_round_mode;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [31:0]     resp_result;
    logic [4:0]      resp_flags;
    logic            resp_timeout;
    logic [31:0]     alu_op_a;
    logic [31:0]     alu_op_b;
    logic [2:0]      alu_op_code;
    logic            alu_mode_fp;
    logic [1:0]      alu_round_mode;
    logic            alu_start;
    logic [31:0]     alu_result;
    logic            alu_valid_out;
    logic [4:0]      alu_flags;
    logic            busy;
    logic [0:0]      grant_id;

    int total = 0;
    int bad   = 0;
    bit never_respond = 1'b0;
    int hold_after    = 0;
    int lat_cnt;
    int hold_cnt;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N), .TIMEOUT_CYCLES(TO), .TIMEOUT_RESULT(32'h7FC00000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b), .req_op_code(req_op_code),
        .req_mode_fp(req_mode_fp), .req_round_mode(req_round_mode),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_flags(resp_flags), .resp_timeout(resp_timeout),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
        .alu_mode_fp(alu_mode_fp), .alu_round_mode(alu_round_mode),
        .alu_start(alu_start), .alu_result(alu_result),
        .alu_valid_out(alu_valid_out), .alu_flags(alu_flags),
        .busy(busy), .grant_id(grant_id)
    );

    // Known IEEE vectors give exact answers; anything else returns a^b with inexact set.
    function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                                 input logic [2:0] op);
        if (op == 3'b010 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (op == 3'b000 && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        if (op == 3'b001 && a == 32'h40400000 && b == 32'h40000000) return 32'h3F800000;
        return a ^ b;
    endfunction

    function automatic logic [4:0] model_flags(input logic [31:0] a, input logic [31:0] b,
                                               input logic [2:0] op);
        if (op == 3'b010 && a == 32'h40000000 && b == 32'h40400000) return 5'b00000;
        if (op == 3'b000 && a == 32'h3F800000 && b == 32'h3F800000) return 5'b00000;
        if (op == 3'b001 && a == 32'h40400000 && b == 32'h40000000) return 5'b00000;
        return 5'b00001;
    endfunction

    // ALU stub: answers 3 cycles into start, then keeps valid_out for hold_after cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_valid_out <= 1'b0;
            alu_result    <= '0;
            alu_flags     <= '0;
            lat_cnt       <= 0;
            hold_cnt      <= 0;
        end else if (alu_start) begin
            hold_cnt <= 0;
            if (!never_respond) begin
                if (lat_cnt == 2) begin
                    alu_valid_out <= 1'b1;
                    alu_result    <= model_result(alu_op_a, alu_op_b, alu_op_code);
                    alu_flags     <= model_flags(alu_op_a, alu_op_b, alu_op_code);
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end
        end else begin
            lat_cnt <= 0;
            if (alu_valid_out) begin
                if (hold_cnt + 1 < hold_after) begin
                    hold_cnt <= hold_cnt + 1;
                end else begin
                    alu_valid_out <= 1'b0;
                    hold_cnt      <= 0;
                end
            end
        end
    end

    task automatic apply_reset();
        rst            = 1'b0;
        req_valid      = '0;
        resp_ready     = '0;
        req_op_a       = '0;
        req_op_b       = '0;
        req_op_code    = '0;
        req_mode_fp    = '0;
        req_round_mode = '0;
        never_respond  = 1'b0;
        hold_after     = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        req_op_a[32*i +: 32]     = a;
        req_op_b[32*i +: 32]     = b;
        req_op_code[3*i +: 3]    = op;
        req_mode_fp[i]           = 1'b1;
        req_round_mode[2*i +: 2] = 2'b00;
    endtask

    // Samples once per negedge until a response appears or the cycle budget runs out.
    task automatic wait_resp(output int start_cycles, output int drain_cycles,
                             output bit ok, output bit multi_ready);
        start_cycles = 0;
        drain_cycles = 0;
        ok           = 1'b0;
        multi_ready  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (resp_valid != '0) begin
                ok = 1'b1;
                break;
            end
            if (alu_start) start_cycles++;
            if (busy && !alu_start) drain_cycles++;
            if ($countones(req_ready) > 1 || (busy && req_ready != '0)) multi_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic ack(input int i);
        resp_ready    = '0;
        resp_ready[i] = 1'b1;
        @(negedge clk);
        resp_ready = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = '0;
        resp_ready = '0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        total++; if (alu_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_start: got %b want 0", alu_start); end
        total++; if (resp_valid !== 2'b00) begin bad++; $display("[TB] FAIL reset_resp_valid: got %b want 00", resp_valid); end
        total++; if (resp_result !== 32'h0) begin bad++; $display("[TB] FAIL reset_result: got %h want 0", resp_result); end
        total++; if (alu_op_a !== 32'h0) begin bad++; $display("[TB] FAIL reset_op_a: got %h want 0", alu_op_a); end
        total++; if (grant_id !== 1'b0) begin bad++; $display("[TB] FAIL reset_grant: got %0d want 0", grant_id); end
        apply_reset();
    endtask

    task automatic test_single();
        int  sc, dc;
        bit  ok, mr;
        apply_reset();
        set_req(0, 32'h40000000, 32'h40400000, 3'b010);
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL single_ready: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        total++; if (alu_start !== 1'b1) begin bad++; $display("[TB] FAIL single_start: got %b want 1", alu_start); end
        total++; if ({alu_op_a, alu_op_b} !== {32'h40000000, 32'h40400000}) begin bad++; $display("[TB] FAIL single_ops: got %h %h want 40000000 40400000", alu_op_a, alu_op_b); end
        total++; if ({alu_op_code, alu_mode_fp} !== {3'b010, 1'b1}) begin bad++; $display("[TB] FAIL single_opcode: got %b %b want 010 1", alu_op_code, alu_mode_fp); end
        wait_resp(sc, dc, ok, mr);
        total++; if (!ok) begin bad++; $display("[TB] FAIL single_timeout_wait: got none want response"); end
        total++; if (sc !== 4) begin bad++; $display("[TB] FAIL single_start_cycles: got %0d want 4", sc); end
        total++; if (dc !== 2) begin bad++; $display("[TB] FAIL single_drain_cycles: got %0d want 2", dc); end
        total++; if (resp_valid !== 2'b01) begin bad++; $display("[TB] FAIL single_resp_valid: got %b want 01", resp_valid); end
        total++; if (resp_result !== 32'h40C00000) begin bad++; $display("[TB] FAIL single_result: got %h want 40c00000", resp_result); end
        total++; if ({resp_flags, resp_timeout} !== 6'b0) begin bad++; $display("[TB] FAIL single_flags: got %b %b want 00000 0", resp_flags, resp_timeout); end
        ack(0);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_idle: got %b want 0", busy); end
        total++; if (resp_result !== 32'h40C00000) begin bad++; $display("[TB] FAIL single_hold_result: got %h want 40c00000", resp_result); end
    endtask

    task automatic test_two_same_cycle();
        int  sc, dc;
        bit  ok, mr0, mr1;
        apply_reset();
        set_req(0, 32'h3F800000, 32'h3F800000, 3'b000);
        set_req(1, 32'h40400000, 32'h40000000, 3'b001);
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL pair_first_ready: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b10;
        wait_resp(sc, dc, ok, mr0);
        total++; if (!ok || resp_valid !== 2'b01) begin bad++; $display("[TB] FAIL pair_first_resp: got %b want 01", resp_valid); end
        total++; if (resp_result !== 32'h40000000) begin bad++; $display("[TB] FAIL pair_first_result: got %h want 40000000", resp_result); end
        ack(0);
        total++; if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL pair_second_ready: got %b want 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        total++; if (grant_id !== 1'b1) begin bad++; $display("[TB] FAIL pair_second_grant: got %0d want 1", grant_id); end
        total++; if ({alu_op_a, alu_op_code} !== {32'h40400000, 3'b001}) begin bad++; $display("[TB] FAIL pair_second_ops: got %h %b want 40400000 001", alu_op_a, alu_op_code); end
        wait_resp(sc, dc, ok, mr1);
        total++; if (!ok || resp_valid !== 2'b10) begin bad++; $display("[TB] FAIL pair_second_resp: got %b want 10", resp_valid); end
        total++; if (resp_result !== 32'h3F800000) begin bad++; $display("[TB] FAIL pair_second_result: got %h want 3f800000", resp_result); end
        total++; if (mr0 || mr1) begin bad++; $display("[TB] FAIL pair_ready_onehot: got %b%b want 00", mr0, mr1); end
        ack(1);
    endtask

    task automatic test_back_to_back();
        int         sc, dc;
        bit         ok, mr;
        logic [0:0] exp_g;
        apply_reset();
        set_req(0, 32'h00000011, 32'h00000022, 3'b000);
        set_req(1, 32'h00000100, 32'h00000300, 3'b000);
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            exp_g = k[0];
            wait_resp(sc, dc, ok, mr);
            total++; if (!ok || grant_id !== exp_g) begin bad++; $display("[TB] FAIL rotate_grant_%0d: got %0d want %0d", k, grant_id, exp_g); end
            total++; if (resp_result !== (exp_g ? 32'h00000200 : 32'h00000033)) begin bad++; $display("[TB] FAIL rotate_result_%0d: got %h want %h", k, resp_result, exp_g ? 32'h00000200 : 32'h00000033); end
            total++; if (resp_flags !== 5'b00001) begin bad++; $display("[TB] FAIL rotate_flags_%0d: got %b want 00001", k, resp_flags); end
            if (k == 5) req_valid = 2'b00;
            ack(int'(exp_g));
        end
        req_valid = 2'b00;
    endtask

    task automatic test_timeout();
        int  sc, dc;
        bit  ok, mr;
        apply_reset();
        never_respond = 1'b1;
        set_req(0, 32'h40000000, 32'h40400000, 3'b010);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        wait_resp(sc, dc, ok, mr);
        total++; if (sc !== TO) begin bad++; $display("[TB] FAIL timeout_start_cycles: got %0d want %0d", sc, TO); end
        total++; if (!ok || resp_valid !== 2'b01) begin bad++; $display("[TB] FAIL timeout_resp_valid: got %b want 01", resp_valid); end
        total++; if (resp_result !== 32'h7FC00000) begin bad++; $display("[TB] FAIL timeout_result: got %h want 7fc00000", resp_result); end
        total++; if ({resp_flags, resp_timeout} !== 6'b100001) begin bad++; $display("[TB] FAIL timeout_flags: got %b %b want 10000 1", resp_flags, resp_timeout); end
        ack(0);
        never_respond = 1'b0;
    endtask

    task automatic test_hold_drain();
        int  sc, dc;
        bit  ok, mr;
        apply_reset();
        hold_after = 3;
        set_req(0, 32'h40000000, 32'h40400000, 3'b010);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        wait_resp(sc, dc, ok, mr);
        total++; if (dc !== 4) begin bad++; $display("[TB] FAIL drain_cycles: got %0d want 4", dc); end
        total++; if (!ok || alu_valid_out !== 1'b0) begin bad++; $display("[TB] FAIL drain_valid_low: got %b want 0", alu_valid_out); end
        set_req(1, 32'h3F800000, 32'h3F800000, 3'b000);
        req_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (resp_valid !== 2'b01 || resp_result !== 32'h40C00000) begin bad++; $display("[TB] FAIL stall_resp_%0d: got %b %h want 01 40c00000", k, resp_valid, resp_result); end
            total++; if (req_ready !== 2'b00 || grant_id !== 1'b0) begin bad++; $display("[TB] FAIL stall_no_grant_%0d: got %b %0d want 00 0", k, req_ready, grant_id); end
        end
        ack(0);
        total++; if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL stall_pending_ready: got %b want 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        total++; if (grant_id !== 1'b1) begin bad++; $display("[TB] FAIL stall_pending_grant: got %0d want 1", grant_id); end
    endtask

    task automatic test_reset_mid();
        int  sc, dc;
        bit  ok, mr;
        apply_reset();
        set_req(0, 32'h3F800000, 32'h3F800000, 3'b000);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        total++; if (alu_start !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_start: got %b want 1", alu_start); end
        #2 rst = 1'b0;
        #1;
        total++; if ({alu_start, busy} !== 2'b00) begin bad++; $display("[TB] FAIL mid_async: got %b%b want 00", alu_start, busy); end
        total++; if (resp_valid !== 2'b00 || alu_op_a !== 32'h0) begin bad++; $display("[TB] FAIL mid_async_outs: got %b %h want 00 0", resp_valid, alu_op_a); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        set_req(1, 32'h40400000, 32'h40000000, 3'b001);
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL mid_restart_ready: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b10;
        wait_resp(sc, dc, ok, mr);
        total++; if (!ok || resp_valid !== 2'b01 || grant_id !== 1'b0) begin bad++; $display("[TB] FAIL mid_restart_resp: got %b %0d want 01 0", resp_valid, grant_id); end
        total++; if (resp_result !== 32'h40000000) begin bad++; $display("[TB] FAIL mid_restart_result: got %h want 40000000", resp_result); end
        req_valid = 2'b00;
        ack(0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_same_cycle();
        test_back_to_back();
        test_timeout();
        test_hold_drain();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got no finish want finish before 100000");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
